// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes used by the
// pipeline decoder, the issue controller and the HI/LO datapath, default
// latencies, counter width and the controller state encoding.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MF    = 3'd7;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;
  localparam int unsigned MD_CNT_W        = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Operations that occupy the unit for a latency period.
  function automatic logic md_is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_cnt.sv
// md_lat_cnt: loadable 5-bit latency down-counter.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   load        - load load_val on the next edge (takes priority)
//   load_val    - latency to load
//   value       - current count; counts down to 0 and holds there
//   last        - value == 1 (final busy cycle)
module md_lat_cnt
  import md_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  output logic [MD_CNT_W-1:0] value,
  output logic                last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign last = (value == MD_CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue and sequencing controller for the multiply/divide unit.
// Decides when an E-stage mult/div/mthi/mtlo may act, owns the latency
// countdown and busy, stalls D for any unit user and pulses the HI/LO commit.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   req         - exception/interrupt taken; blocks all E-stage effects
//   e_md_op     - E-stage operation (md_pkg codes)
//   d_md_use    - D-stage instruction uses the unit
//   md_start    - operand-latch pulse to the datapath (comb)
//   md_op_q     - latched operation of the in-flight job
//   md_commit   - one-cycle HI/LO commit pulse (comb)
//   hi_we/lo_we - direct mthi/mtlo write enables (comb)
//   busy        - job in flight (registered)
//   stall_d     - freeze D stage (comb)
//   err         - sticky protocol violation (op issued while running)
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] e_md_op,
  input  logic       d_md_use,
  output logic       md_start,
  output logic [2:0] md_op_q,
  output logic       md_commit,
  output logic       hi_we,
  output logic       lo_we,
  output logic       busy,
  output logic       stall_d,
  output logic       err
);

  localparam logic [MD_CNT_W-1:0] MULT_LAT_C = MD_CNT_W'(MULT_LAT);
  localparam logic [MD_CNT_W-1:0] DIV_LAT_C  = MD_CNT_W'(DIV_LAT);

  md_state_e             state;
  logic                  e_ok;
  logic                  issue;
  logic                  violation;
  logic [MD_CNT_W-1:0]   lat_sel;
  logic [MD_CNT_W-1:0]   cnt;
  logic                  cnt_last;

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    e_ok      = (state == ST_IDLE) && !req && !reset;
    issue     = e_ok && md_is_muldiv(e_md_op);
    lat_sel   = md_is_mul(e_md_op) ? MULT_LAT_C : DIV_LAT_C;
    md_start  = issue;
    hi_we     = e_ok && (e_md_op == MD_MTHI);
    lo_we     = e_ok && (e_md_op == MD_MTLO);
    md_commit = !reset && (state == ST_RUN) && cnt_last;
    stall_d   = !reset && d_md_use && (busy || issue);
    // An op being flushed by req is not treated as a violation.
    violation = (state == ST_RUN) && !req &&
                (e_md_op != MD_NONE) && (e_md_op != MD_MF);
  end

  md_lat_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .load_val (lat_sel),
    .value    (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      err     <= 1'b0;
      md_op_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            md_op_q <= e_md_op;
            state   <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cnt_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          if (violation) begin
            err <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [2:0] e_md_op;
  logic       d_md_use;
  logic       md_start;
  logic [2:0] md_op_q;
  logic       md_commit;
  logic       hi_we;
  logic       lo_we;
  logic       busy;
  logic       stall_d;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .e_md_op   (e_md_op),
    .d_md_use  (d_md_use),
    .md_start  (md_start),
    .md_op_q   (md_op_q),
    .md_commit (md_commit),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .busy      (busy),
    .stall_d   (stall_d),
    .err       (err)
  );

  // Advance to 1ns after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; d_md_use = 1'b1; e_md_op = MD_MULT;
    #2;
    n_checks++;
    if ({md_start, md_commit, hi_we, lo_we, busy, stall_d, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {md_start, md_commit, hi_we, lo_we, busy, stall_d, err});
    end
    n_checks++;
    if (md_op_q !== 3'd0) begin
      n_fail++; $display("FAIL reset_op_q: got %0d want 0", md_op_q);
    end
    e_md_op = MD_NONE; d_md_use = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    e_md_op = MD_MULT;
    #1;
    n_checks++;
    if (md_start !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mult_t0: got start=%b busy=%b want start=1 busy=0", md_start, busy);
    end
    for (int t = 1; t <= 6; t++) begin
      tick();
      e_md_op = MD_NONE;
      #1;
      n_checks++;
      if (busy !== (t <= 5) || md_commit !== (t == 5) || md_start !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_T%0d: got busy=%b commit=%b start=%b want busy=%b commit=%b start=0",
                 t, busy, md_commit, md_start, (t <= 5), (t == 5));
      end
      if (t == 1) begin
        n_checks++;
        if (md_op_q !== MD_MULT) begin
          n_fail++; $display("FAIL mult_op_q: got %0d want 1", md_op_q);
        end
      end
    end
  endtask

  task automatic test_divu_stall();
    int stalls = 0;
    d_md_use = 1'b1;
    e_md_op  = MD_DIVU;
    #1;
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) begin
        tick();
        e_md_op = MD_NONE;
        #1;
      end
      if (stall_d === 1'b1) stalls++;
      n_checks++;
      if (stall_d !== (t <= 10) || md_commit !== (t == 10)) begin
        n_fail++;
        $display("FAIL divu_T%0d: got stall=%b commit=%b want stall=%b commit=%b",
                 t, stall_d, md_commit, (t <= 10), (t == 10));
      end
      if (t == 1) begin
        n_checks++;
        if (md_op_q !== MD_DIVU) begin
          n_fail++; $display("FAIL divu_op_q: got %0d want 4", md_op_q);
        end
      end
    end
    n_checks++;
    if (stalls != 11) begin
      n_fail++; $display("FAIL divu_stall_count: got %0d want 11", stalls);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_req_block();
    req = 1'b1; d_md_use = 1'b1; e_md_op = MD_MULT;
    #1;
    n_checks++;
    if (md_start !== 1'b0 || stall_d !== 1'b0) begin
      n_fail++; $display("FAIL req_block_t0: got start=%b stall=%b want 0 0", md_start, stall_d);
    end
    tick();
    req = 1'b0; e_md_op = MD_NONE;
    #1;
    n_checks++;
    if (busy !== 1'b0 || stall_d !== 1'b0) begin
      n_fail++; $display("FAIL req_block_t1: got busy=%b stall=%b want 0 0", busy, stall_d);
    end
    // Still IDLE: a fresh MTLO acts immediately.
    e_md_op = MD_MTLO;
    #1;
    n_checks++;
    if (lo_we !== 1'b1) begin
      n_fail++; $display("FAIL req_block_idle: got lo_we=%b want 1", lo_we);
    end
    d_md_use = 1'b0;
    tick();
    e_md_op = MD_NONE;
  endtask

  task automatic test_mthi_mtlo();
    e_md_op = MD_MTHI;
    #1;
    n_checks++;
    if (hi_we !== 1'b1 || lo_we !== 1'b0 || md_start !== 1'b0) begin
      n_fail++; $display("FAIL mthi: got hi=%b lo=%b start=%b want 1 0 0", hi_we, lo_we, md_start);
    end
    tick();
    e_md_op = MD_MTLO;
    #1;
    n_checks++;
    if (lo_we !== 1'b1 || hi_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mtlo: got hi=%b lo=%b busy=%b want 0 1 0", hi_we, lo_we, busy);
    end
    tick();
    req = 1'b1; e_md_op = MD_MTHI;
    #1;
    n_checks++;
    if (hi_we !== 1'b0) begin
      n_fail++; $display("FAIL mthi_req: got hi=%b want 0", hi_we);
    end
    tick();
    req = 1'b0; e_md_op = MD_NONE;
    #1;
    n_checks++;
    if (hi_we !== 1'b0 || lo_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mt_idle: got hi=%b lo=%b busy=%b want 0 0 0", hi_we, lo_we, busy);
    end
  endtask

  task automatic test_reset_abort();
    int commits = 0;
    e_md_op = MD_DIV;
    #1;
    n_checks++;
    if (md_start !== 1'b1) begin
      n_fail++; $display("FAIL abort_start: got %b want 1", md_start);
    end
    tick(); e_md_op = MD_NONE;
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || md_op_q !== 3'd0 || md_commit !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got busy=%b op_q=%0d commit=%b want 0 0 0",
                         busy, md_op_q, md_commit);
    end
    #1;
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (md_commit !== 1'b0 || busy !== 1'b0) commits++;
    end
    n_checks++;
    if (commits != 0) begin
      n_fail++; $display("FAIL abort_no_commit: got %0d active cycles want 0", commits);
    end
  endtask

  task automatic test_violation();
    e_md_op = MD_MULTU;
    #1;
    n_checks++;
    if (md_start !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL viol_t0: got start=%b err=%b want 1 0", md_start, err);
    end
    tick();  // T1: MF while running is legal
    e_md_op = MD_MF;
    #1;
    tick();  // T2: DIV while running is a violation
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL viol_mf: got err=%b want 0", err);
    end
    e_md_op = MD_DIV;
    #1;
    n_checks++;
    if (md_start !== 1'b0) begin
      n_fail++; $display("FAIL viol_restart: got start=%b want 0", md_start);
    end
    tick();  // T3
    e_md_op = MD_MTHI;
    #1;
    n_checks++;
    if (err !== 1'b1 || hi_we !== 1'b0) begin
      n_fail++; $display("FAIL viol_err: got err=%b hi=%b want 1 0", err, hi_we);
    end
    for (int t = 4; t <= 7; t++) begin
      tick();
      e_md_op = MD_NONE;
      #1;
      n_checks++;
      if (md_commit !== (t == 5) || busy !== (t <= 5) || err !== 1'b1) begin
        n_fail++;
        $display("FAIL viol_T%0d: got commit=%b busy=%b err=%b want %b %b 1",
                 t, md_commit, busy, err, (t == 5), (t <= 5));
      end
      if (t == 5) begin
        n_checks++;
        if (md_op_q !== MD_MULTU) begin
          n_fail++; $display("FAIL viol_op_q: got %0d want 2", md_op_q);
        end
      end
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL viol_clear: got err=%b want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    e_md_op = MD_MULT;
    #1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      e_md_op = (t == 6) ? MD_DIV : MD_NONE;
      #1;
      if (t == 6) begin
        n_checks++;
        if (md_start !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_issue: got start=%b busy=%b want 1 0", md_start, busy);
        end
      end
      n_checks++;
      if (md_commit !== (t == 5 || t == 16) || busy !== (t != 6 && t != 17)) begin
        n_fail++;
        $display("FAIL b2b_T%0d: got commit=%b busy=%b want %b %b",
                 t, md_commit, busy, (t == 5 || t == 16), (t != 6 && t != 17));
      end
      if (t == 7) begin
        n_checks++;
        if (md_op_q !== MD_DIV) begin
          n_fail++; $display("FAIL b2b_op_q: got %0d want 3", md_op_q);
        end
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_err: got err=%b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_req_block();
    test_mthi_mtlo();
    test_reset_abort();
    test_violation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
